// File: rtl/display_formatter.sv
// Converts signed receiver samples into four display codes {sign, hundreds, tens, units}
// using a sequential double-dabble conversion, with a one-entry pending buffer.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting; starts from pending entry first, else from rx_valid
// S_ABS    | take magnitude of latched sample, clear BCD, load iteration counter
// S_CONV   | one add-3/shift step per cycle, DATA_WIDTH steps
// S_FORMAT | register display word; display_update pulses next cycle
module display_formatter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_error,
  output logic [15:0]           signal_to_display,
  output logic                  display_update,
  output logic                  busy,
  output logic                  dropped
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam int SH_W  = 12 + DATA_WIDTH;

  localparam logic [3:0] CODE_MINUS = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hC;
  localparam logic [15:0] WORD_ERROR = 16'hBBBB;
  localparam logic [15:0] WORD_RESET = 16'hCCCC;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ABS,
    S_CONV,
    S_FORMAT
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] mag_q;
  logic [11:0]           bcd_q;
  logic [CNT_W-1:0]      iter_cnt;

  logic [DATA_WIDTH-1:0] pend_data;
  logic                  pend_err;
  logic                  pend_valid;

  logic                  start;
  logic [DATA_WIDTH-1:0] start_data;
  logic                  start_err;
  logic                  pend_load;
  logic                  pend_valid_nxt;
  logic                  drop_nxt;
  logic [11:0]           bcd_adj;
  logic [SH_W-1:0]       shifted;
  logic [3:0]            hund, tens, units;
  logic [15:0]           fmt_word;

  assign busy = (state != S_IDLE);

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    start_data = pend_valid ? pend_data : rx_data;
    start_err  = pend_valid ? pend_err  : rx_error;
    case (state)
      S_IDLE: begin
        if (pend_valid || rx_valid) begin
          start     = 1'b1;
          state_nxt = S_ABS;
        end
      end
      S_ABS:    state_nxt = S_CONV;
      S_CONV:   if (iter_cnt == '0) state_nxt = S_FORMAT;
      S_FORMAT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // In IDLE the pending entry is consumed as rx_valid refills it, so no drop there.
  always_comb begin
    pend_load      = 1'b0;
    pend_valid_nxt = pend_valid;
    drop_nxt       = 1'b0;
    if (state == S_IDLE) begin
      pend_load      = rx_valid && pend_valid;
      pend_valid_nxt = rx_valid && pend_valid;
    end else begin
      pend_load      = rx_valid;
      pend_valid_nxt = pend_valid || rx_valid;
      drop_nxt       = rx_valid && pend_valid;
    end
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
    shifted = {bcd_adj, mag_q} << 1;
  end

  always_comb begin
    hund  = bcd_q[11:8];
    tens  = bcd_q[7:4];
    units = bcd_q[3:0];
    fmt_word[15:12] = data_q[DATA_WIDTH-1] ? CODE_MINUS : CODE_BLANK;
    fmt_word[11:8]  = (hund == 4'd0) ? CODE_BLANK : hund;
    fmt_word[7:4]   = (hund == 4'd0 && tens == 4'd0) ? CODE_BLANK : tens;
    fmt_word[3:0]   = units;
    if (err_q) fmt_word = WORD_ERROR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      data_q            <= '0;
      err_q             <= 1'b0;
      mag_q             <= '0;
      bcd_q             <= '0;
      iter_cnt          <= '0;
      pend_data         <= '0;
      pend_err          <= 1'b0;
      pend_valid        <= 1'b0;
      signal_to_display <= WORD_RESET;
      display_update    <= 1'b0;
      dropped           <= 1'b0;
    end else begin
      state          <= state_nxt;
      display_update <= 1'b0;
      dropped        <= drop_nxt;
      pend_valid     <= pend_valid_nxt;
      if (pend_load) begin
        pend_data <= rx_data;
        pend_err  <= rx_error;
      end
      if (start) begin
        data_q <= start_data;
        err_q  <= start_err;
      end
      case (state)
        S_ABS: begin
          // Most negative input wraps to 2^(W-1), which still fits unsigned.
          mag_q    <= data_q[DATA_WIDTH-1] ? (~data_q + 1'b1) : data_q;
          bcd_q    <= '0;
          iter_cnt <= CNT_W'(DATA_WIDTH - 1);
        end
        S_CONV: begin
          bcd_q    <= shifted[SH_W-1:DATA_WIDTH];
          mag_q    <= shifted[DATA_WIDTH-1:0];
          iter_cnt <= iter_cnt - 1'b1;
        end
        S_FORMAT: begin
          signal_to_display <= fmt_word;
          display_update    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_display_formatter.sv
// Self-checking bench for display_formatter: scoreboard of expected display words,
// popped whenever display_update pulses, plus directed reset/latency/drop checks.
module tb_display_formatter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_error = 1'b0;
  logic [15:0] signal_to_display;
  logic        display_update;
  logic        busy;
  logic        dropped;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  int drop_cnt = 0;
  logic [15:0] sb[$];
  logic prev_upd = 1'b0;

  always #5 clk = ~clk;

  display_formatter #(.DATA_WIDTH(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_error          (rx_error),
    .signal_to_display (signal_to_display),
    .display_update    (display_update),
    .busy              (busy),
    .dropped           (dropped)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor
  initial begin
    logic [15:0] exp_word;
    forever begin
      @(negedge clk);
      if (dropped) drop_cnt++;
      if (display_update) begin
        upd_cnt++;
        check("upd_width", {15'd0, prev_upd}, 16'd0);
        check("sb_nonempty", {15'd0, sb.size() > 0}, 16'd1);
        if (sb.size() > 0) begin
          exp_word = sb.pop_front();
          check("display_word", signal_to_display, exp_word);
        end
      end
      prev_upd = display_update;
    end
  end

  task automatic send(input logic [7:0] d, input logic e, input logic [15:0] exp_word);
    @(negedge clk);
    rx_data  = d;
    rx_error = e;
    rx_valid = 1'b1;
    sb.push_back(exp_word);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic wait_idle();
    logic done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("idle_timeout", {15'd0, done}, 16'd1);
  endtask

  initial begin
    int upd_before;
    // T1: reset
    #400;
    @(negedge clk);
    check("rst_word", signal_to_display, 16'hCCCC);
    check("rst_busy", {15'd0, busy}, 16'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_word", signal_to_display, 16'hCCCC);
    check("post_rst_upd", upd_cnt[15:0], 16'd0);

    // T2: latency and pulse width for 94
    @(negedge clk);
    rx_data = 8'd94; rx_valid = 1'b1;
    sb.push_back(16'hCC94);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 check("lat_pre_upd", {15'd0, display_update}, 16'd0);
    @(posedge clk);
    #1 check("lat_upd", {15'd0, display_update}, 16'd1);
    check("lat_word", signal_to_display, 16'hCC94);
    @(posedge clk);
    #1 check("lat_upd_fall", {15'd0, display_update}, 16'd0);
    wait_idle();

    send(8'd0, 1'b0, 16'hCCC0);     wait_idle();
    send(8'd127, 1'b0, 16'hC127);   wait_idle();
    send(8'd105, 1'b0, 16'hC105);   wait_idle();

    // T3: negatives
    send(8'hE0, 1'b0, 16'hAC32);    wait_idle();
    send(8'h80, 1'b0, 16'hA128);    wait_idle();
    send(8'hFF, 1'b0, 16'hACC1);    wait_idle();
    send(8'h9C, 1'b0, 16'hA100);    wait_idle();
    send(8'h81, 1'b0, 16'hA127);    wait_idle();

    // T4: error sample, then clean; stray rx_error ignored
    send(8'd55, 1'b1, 16'hBBBB);    wait_idle();
    upd_before = upd_cnt;
    @(negedge clk); rx_error = 1'b1;
    repeat (5) @(negedge clk); rx_error = 1'b0;
    repeat (15) @(negedge clk);
    check("stray_err_upd", 16'(upd_cnt), 16'(upd_before));
    check("stray_err_word", signal_to_display, 16'hBBBB);
    send(8'd10, 1'b0, 16'hCC10);    wait_idle();

    // T5: 10, 20, 30 on consecutive cycles; 20 is overwritten
    check("drop_none_yet", 16'(drop_cnt), 16'd0);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'd10; sb.push_back(16'hCC10);
    @(negedge clk); rx_data = 8'd20;
    @(negedge clk); rx_data = 8'd30; sb.push_back(16'hCC30);
    @(negedge clk); rx_valid = 1'b0;
    wait_idle();
    check("drop_cnt", 16'(drop_cnt), 16'd1);

    // T6: reset during CONV iteration 4 of -5
    upd_before = upd_cnt;
    @(negedge clk);
    rx_data = 8'hFB; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    rx_data = 8'd33; rx_valid = 1'b1;   // parks in pending, must be cleared by reset
    @(negedge clk); rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_busy_before", {15'd0, busy}, 16'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_word", signal_to_display, 16'hCCCC);
    check("t6_busy", {15'd0, busy}, 16'd0);
    repeat (25) @(negedge clk);
    check("t6_no_upd", 16'(upd_cnt), 16'(upd_before));
    check("t6_pend_empty", {15'd0, busy}, 16'd0);
    send(8'd7, 1'b0, 16'hCCC7);     wait_idle();
    repeat (20) @(negedge clk);
    check("t6_single_upd", 16'(upd_cnt), 16'(upd_before + 1));

    check("sb_drained", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed %0d expected 0", 1);
    $fatal(1);
  end

endmodule
